// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings and default latencies for mdu_ctrl.
// The DIV state exists only when MDU_DIV_EN is defined.
package mdu_pkg;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MULT} state_t;
`endif
endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle HI/LO multiply/divide unit with busy counter and stall request.
// Divider (DIV/DIVU) is built only when MDU_DIV_EN is defined; otherwise ops 2/3 are ignored.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);
    if (MULT_LAT < 1 || MULT_LAT > 15 || DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_lat
        $error("mdu_ctrl: latency parameters must be in 1..15");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic [63:0] mul_a, mul_b, prod;

    // Sign/zero-extend to 64 bits so one truncated product serves MULT and MULTU.
    assign mul_a = {op[0] ? 32'b0 : {32{rs_val[31]}}, rs_val};
    assign mul_b = {op[0] ? 32'b0 : {32{rt_val[31]}}, rt_val};
    assign prod  = mul_a * mul_b;

`ifdef MDU_DIV_EN
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot, rem;
    always_comb begin
        quot_s = 32'sd0;
        rem_s  = 32'sd0;
        quot   = 32'd0;
        rem    = 32'd0;
        if (rt_val != 32'd0) begin
            quot_s = $signed(rs_val) / $signed(rt_val);
            rem_s  = $signed(rs_val) % $signed(rt_val);
            quot   = op[0] ? rs_val / rt_val : quot_s;
            rem    = op[0] ? rs_val % rt_val : rem_s;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        if (state_q == S_IDLE) begin
            if (start && (op == OP_MULT || op == OP_MULTU)) begin
                hi_tmp_d = prod[63:32];
                lo_tmp_d = prod[31:0];
                cnt_d    = 4'(MULT_LAT);
                busy_d   = 1'b1;
                state_d  = S_MULT;
            end
`ifdef MDU_DIV_EN
            else if (start && (op == OP_DIV || op == OP_DIVU)) begin
                hi_tmp_d = (rt_val == 32'd0) ? hi_q : rem;
                lo_tmp_d = (rt_val == 32'd0) ? lo_q : quot;
                cnt_d    = 4'(DIV_LAT);
                busy_d   = 1'b1;
                state_d  = S_DIV;
            end
`endif
            else if (start && op == OP_MTHI) hi_d = rs_val;
            else if (start && op == OP_MTLO) lo_d = rs_val;
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d    = hi_tmp_q;
                lo_d    = lo_tmp_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign stall_md = md_use_D & (start | busy_q);
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (default latencies 5/10).
// Divide checks follow MDU_DIV_EN: real results when defined, ignored ops otherwise.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, md_use_D, busy, stall_md;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val, hi, lo;
    int          total = 0, bad = 0;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .md_use_D(md_use_D), .busy(busy), .hi(hi), .lo(lo), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then check busy for lat cycles and the committed hi/lo.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, b,
                          input int lat, input logic [31:0] exp_hi, exp_lo);
        logic [31:0] old_hi, old_lo;
        old_hi = hi;
        old_lo = lo;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (i == lat - 1) begin
                chk({tag, "_hi_hold"}, hi, old_hi);
                chk({tag, "_lo_hold"}, lo, old_lo);
            end
            step();
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; md_use_D = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);
        reset = 1'b1;
        step();

        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

`ifdef MDU_DIV_EN
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        op = 3'd2; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("div_off_busy", {31'd0, busy}, 32'd0);
        chk("div_off_hi", hi, 32'h0000_0001);
        chk("div_off_lo", lo, 32'hFFFF_FFFE);
`endif

        op = 3'd4; rs_val = 32'h11; start = 1'b1;
        step();
        op = 3'd5; rs_val = 32'h22;
        step();
        start = 1'b0;
        chk("mthi_hi", hi, 32'h11);
        chk("mtlo_lo", lo, 32'h22);
`ifdef MDU_DIV_EN
        run_op("divu0", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
`else
        op = 3'd3; rs_val = 32'd5; rt_val = 32'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("divu_off_busy", {31'd0, busy}, 32'd0);
        chk("divu_off_hi", hi, 32'h11);
        chk("divu_off_lo", lo, 32'h22);
`endif

        md_use_D = 1'b1;
        op = 3'd0; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        #1;
        chk("stall_on_start", {31'd0, stall_md}, 32'd1);
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy", {31'd0, stall_md}, 32'd1);
            if (i == 2) begin
                op = 3'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF; start = 1'b1;
                step();
                start = 1'b0;
            end else step();
        end
        chk("stall_after", {31'd0, stall_md}, 32'd0);
        chk("stall_busy_end", {31'd0, busy}, 32'd0);
        chk("ignored_hi", hi, 32'd0);
        chk("ignored_lo", lo, 32'd12);
        md_use_D = 1'b0;

        op = 3'd5; rs_val = 32'h5A; start = 1'b1;
        step();
        start = 1'b0;
        chk("mtlo5a_lo", lo, 32'h5A);
        chk("mtlo5a_busy", {31'd0, busy}, 32'd0);
        chk("mtlo5a_hi", hi, 32'd0);

        op = 3'd6; rs_val = 32'hDEAD; rt_val = 32'h3; start = 1'b1;
        step();
        op = 3'd7;
        step();
        start = 1'b0;
        chk("rsvd_busy", {31'd0, busy}, 32'd0);
        chk("rsvd_hi", hi, 32'd0);
        chk("rsvd_lo", lo, 32'h5A);

        op = 3'd0; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int i = 0; i < 6; i++) step();
        chk("abort_late_busy", {31'd0, busy}, 32'd0);
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        reset = 1'b0; op = 3'd5; rs_val = 32'h77; start = 1'b1;
        step();
        reset = 1'b1; start = 1'b0;
        chk("rst_prio_lo", lo, 32'd0);
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
